tdm_demux_1to8: RTL

//  Sequential 1:8 time-division demultiplexer: receive end of an 8-slot TDM link.
//   - Input: one N-bit word per valid cycle, frame marker on slot 0.
//   - Output: word steered to one of 8 registered outputs by an internal slot counter.

---
 rtl/tdm_pkg.sv | 10 +
 rtl/tdm_demux_1to8_slot_decoder.sv | 12 +
 rtl/tdm_demux_1to8.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and types for the 8-slot TDM receive path.
package tdm_pkg;

    localparam int TDM_SLOTS  = 8;
    localparam int TDM_SLOT_W = 3;

    typedef enum logic {HUNT, RUN} tdm_state_t;
    typedef logic [TDM_SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_demux_1to8_slot_decoder.sv
// slot_decoder_3to8: slot index to one-hot write enable, all-zero when not enabled.
module slot_decoder_3to8
    import tdm_pkg::*;
(
    input  logic [TDM_SLOT_W-1:0] slot_i,
    input  logic                  en_i,
    output logic [TDM_SLOTS-1:0]  onehot_o
);

    always_comb onehot_o = en_i ? ({{(TDM_SLOTS-1){1'b0}}, 1'b1} << slot_i) : '0;

endmodule

// File: rtl/tdm_demux_1to8.sv
// tdm_demux_1to8: 1:8 TDM demultiplexer with frame-marker lock tracking.
// TDM_DOUBLE_BUFFER_EN: stage slots 0..6 in shadow registers and publish the whole frame at slot 7.
module tdm_demux_1to8
    import tdm_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [N-1:0]         d0,
    output logic [N-1:0]         d1,
    output logic [N-1:0]         d2,
    output logic [N-1:0]         d3,
    output logic [N-1:0]         d4,
    output logic [N-1:0]         d5,
    output logic [N-1:0]         d6,
    output logic [N-1:0]         d7,
    output logic [TDM_SLOTS-1:0] d_strobe,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic                 locked
);

    tdm_state_t             state_q, state_d;
    slot_t                  slot_q, slot_d, wr_slot;
    logic                   wr_en, err_d;
    logic [TDM_SLOTS-1:0]   wr_oh;
    logic [N-1:0]           d_q [TDM_SLOTS];
    logic [TDM_SLOTS-1:0]   strobe_q;
    logic                   fd_q, err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wr_en   = 1'b0;
        wr_slot = slot_q;
        err_d   = 1'b0;
        if (din_valid) begin
            if (state_q == HUNT) begin
                if (frame_sync) begin
                    wr_en   = 1'b1;
                    wr_slot = '0;
                    slot_d  = slot_t'(1);
                    state_d = RUN;
                end
            end else if (frame_sync) begin
                // A marker away from slot 0 resyncs onto it rather than dropping lock.
                err_d   = slot_q != '0;
                wr_en   = 1'b1;
                wr_slot = '0;
                slot_d  = slot_t'(1);
            end else if (slot_q == '0) begin
                err_d   = 1'b1;
                state_d = HUNT;
            end else begin
                wr_en   = 1'b1;
                slot_d  = slot_q + slot_t'(1);
            end
        end
    end

    slot_decoder_3to8 u_dec (
        .slot_i   (wr_slot),
        .en_i     (wr_en),
        .onehot_o (wr_oh)
    );

`ifdef TDM_DOUBLE_BUFFER_EN
    logic [N-1:0] sh_q [TDM_SLOTS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TDM_SLOTS; k++) d_q[k] <= '0;
            for (int k = 0; k < TDM_SLOTS - 1; k++) sh_q[k] <= '0;
            strobe_q <= '0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int k = 0; k < TDM_SLOTS - 1; k++)
                if (wr_oh[k]) sh_q[k] <= din;
            if (wr_oh[TDM_SLOTS-1]) begin
                for (int k = 0; k < TDM_SLOTS - 1; k++) d_q[k] <= sh_q[k];
                d_q[TDM_SLOTS-1] <= din;
            end
            strobe_q <= {TDM_SLOTS{wr_oh[TDM_SLOTS-1]}};
            fd_q     <= wr_oh[TDM_SLOTS-1];
            err_q    <= err_d;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TDM_SLOTS; k++) d_q[k] <= '0;
            strobe_q <= '0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int k = 0; k < TDM_SLOTS; k++)
                if (wr_oh[k]) d_q[k] <= din;
            strobe_q <= wr_oh;
            fd_q     <= wr_oh[TDM_SLOTS-1];
            err_q    <= err_d;
        end
    end
`endif

    always_comb begin
        locked     = state_q == RUN;
        d0         = d_q[0];
        d1         = d_q[1];
        d2         = d_q[2];
        d3         = d_q[3];
        d4         = d_q[4];
        d5         = d_q[5];
        d6         = d_q[6];
        d7         = d_q[7];
        d_strobe   = strobe_q;
        frame_done = fd_q;
        sync_err   = err_q;
    end

endmodule
